// File: rtl/bcd_pkg.sv
// Shared BCD/seven-segment digit codes and the converter state encoding.
// Latency: n/a (constants only). Backpressure: n/a.
// The seven-segment decoder side imports the same code constants.
package bcd_pkg;

  localparam logic [3:0] BCD_E    = 4'b1010;
  localparam logic [3:0] BCD_F    = 4'b1100;
  localparam logic [3:0] BCD_DASH = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational. Backpressure: none.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_encoder.sv
// Sequential shift-and-add-3 binary to BCD converter; SIGNED_INPUT_EN selects two's complement input.
// Latency: done in cycle E+WIDTH+1 after the accepting edge E; one conversion per WIDTH+2 cycles.
// Backpressure: start is ignored (not queued) while busy is high.
module bin2bcd_encoder
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow,
  output logic                neg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_adj;
  logic [AW-1:0]    acc_shl;
  logic [WIDTH-1:0] sr_shl;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             ovf_nxt;
  logic [WIDTH-1:0] mag;
  logic             last_shift;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
        .din  (acc[4*g +: 4]),
        .dout (acc_adj[4*g +: 4])
      );
    end
  endgenerate

  // Corrected digits and binary shift left as one register; the bit leaving the top digit means overflow.
  assign acc_shl    = {acc_adj[AW-2:0], sr[WIDTH-1]};
  assign sr_shl     = {sr[WIDTH-2:0], 1'b0};
  assign ovf_nxt    = ovf | acc_adj[AW-1];
  assign last_shift = (state == SHIFT) && (cnt == CW'(1));

`ifdef SIGNED_INPUT_EN
  logic sgn;
  // Two's complement negate in WIDTH bits maps -2^(WIDTH-1) onto its own unsigned magnitude.
  assign mag = bin[WIDTH-1] ? (~bin + WIDTH'(1)) : bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn <= 1'b0;
      neg <= 1'b0;
    end else begin
      if (state == IDLE && start) sgn <= bin[WIDTH-1];
      if (last_shift)             neg <= sgn;
    end
  end
`else
  assign mag = bin;
  assign neg = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sr  <= mag;
        acc <= '0;
        ovf <= 1'b0;
        cnt <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        sr  <= sr_shl;
        acc <= acc_shl;
        ovf <= ovf_nxt;
        cnt <= cnt - CW'(1);
      end
      // Results land on the edge into DONE so they are valid while done is high.
      if (last_shift) begin
        bcd      <= ovf_nxt ? {DIGITS{BCD_E}} : acc_shl;
        overflow <= ovf_nxt;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bin2bcd_encoder.sv
// Directed and random checks of bin2bcd_encoder (4-digit and 2-digit instances) against an arithmetic model.
module tb_bin2bcd_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  bin;
  logic        busy4, done4, ovf4, neg4;
  logic        busy2, done2, ovf2, neg2;
  logic [15:0] bcd4;
  logic [7:0]  bcd2;

  int errors = 0;
  int checks = 0;
  int lat;
  int nd;
  logic [9:0] v;

  always #5 clk = ~clk;

  bin2bcd_encoder #(.WIDTH(10), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy4), .done(done4),
    .bcd(bcd4), .overflow(ovf4), .neg(neg4)
  );

  bin2bcd_encoder #(.WIDTH(10), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy2), .done(done2),
    .bcd(bcd2), .overflow(ovf2), .neg(neg2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input logic [9:0] b);
`ifdef SIGNED_INPUT_EN
    return b[9] ? 1024 - int'(b) : int'(b);
`else
    return int'(b);
`endif
  endfunction

  function automatic logic neg_of(input logic [9:0] b);
`ifdef SIGNED_INPUT_EN
    return b[9];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] ref_bcd(input int m, input int nd_dig, output logic ov);
    int lim = 1;
    int x;
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < nd_dig; i++) lim *= 10;
    ov = (m >= lim);
    x = m;
    for (int i = 0; i < nd_dig; i++) begin
      if (ov) r[4*i +: 4] = 4'hA;
      else begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  task automatic check_res(input string tag, input logic [9:0] b);
    logic [15:0] e4, e2;
    logic        o4, o2;
    e4 = ref_bcd(mag_of(b), 4, o4);
    e2 = ref_bcd(mag_of(b), 2, o2);
    check({tag, "/done"}, 32'(done4), 32'd1);
    check({tag, "/bcd4"}, 32'(bcd4), 32'(e4));
    check({tag, "/ovf4"}, 32'(ovf4), 32'(o4));
    check({tag, "/neg4"}, 32'(neg4), 32'(neg_of(b)));
    check({tag, "/bcd2"}, 32'(bcd2), 32'(e2[7:0]));
    check({tag, "/ovf2"}, 32'(ovf2), 32'(o2));
    check({tag, "/neg2"}, 32'(neg2), 32'(neg_of(b)));
  endtask

  // One-cycle start; lat counts cycles from the accepting edge to the done cycle.
  task automatic run(input logic [9:0] b, output int l);
    @(negedge clk);
    bin   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l = 1;
    while (!done4 && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("rst/busy", 32'(busy4), 32'd0);
    check("rst/done", 32'(done4), 32'd0);
    check("rst/bcd4", 32'(bcd4), 32'd0);
    check("rst/ovf4", 32'(ovf4), 32'd0);
    check("rst/neg4", 32'(neg4), 32'd0);
    check("rst/bcd2", 32'(bcd2), 32'd0);
    rst = 1'b0;

    run(10'd1023, lat);
    check("lat1023", 32'(lat), 32'd11);
    check_res("v1023", 10'd1023);
    @(negedge clk);
    check("done_pulse", 32'(done4), 32'd0);
    check("idle_busy", 32'(busy4), 32'd0);

    // start held high across two conversions
    bin   = 10'd0;
    start = 1'b1;
    @(negedge clk);
    check("b2b_busy", 32'(busy4), 32'd1);
    lat = 1;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("lat0", 32'(lat), 32'd11);
    check_res("v0", 10'd0);
    bin = 10'd999;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done4 && lat < 40);
    start = 1'b0;
    check("b2b_gap", 32'(lat), 32'd12);
    check_res("v999", 10'd999);

    run(10'd100, lat);
    check_res("v100", 10'd100);
    run(10'd99, lat);
    check_res("v99", 10'd99);
    v = 10'd987;  // -37
    run(v, lat);
    check_res("vm37", v);
    run(10'd512, lat);  // -512 when signed
    check_res("vm512", 10'd512);
    run(10'd511, lat);
    check_res("v511", 10'd511);

    repeat (20) begin
      v = 10'($urandom_range(0, 1023));
      run(v, lat);
      check("rand_lat", 32'(lat), 32'd11);
      check_res("rand", v);
    end

    // a second start 3 cycles into a conversion must be dropped
    @(negedge clk);
    bin   = 10'd321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    bin   = 10'd654;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = 10'd0;
    nd = 0;
    repeat (25) begin
      if (done4) begin
        nd++;
        check_res("ign", 10'd321);
      end
      @(negedge clk);
    end
    check("ign_count", 32'(nd), 32'd1);

    // reset 5 cycles into SHIFT aborts the conversion
    bin   = 10'd77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy4), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort/busy", 32'(busy4), 32'd0);
    check("abort/done", 32'(done4), 32'd0);
    check("abort/bcd4", 32'(bcd4), 32'd0);
    check("abort/bcd2", 32'(bcd2), 32'd0);
    check("abort/ovf4", 32'(ovf4), 32'd0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done4 || done2) nd++;
    end
    check("abort/no_done", 32'(nd), 32'd0);

    run(10'd42, lat);
    check("post_rst_lat", 32'(lat), 32'd11);
    check_res("v42", 10'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
